// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WR,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WAIT_RD
  } state_t;

  localparam int         RW_BIT       = 7;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register bus between the SPI bridge (master) and the register file (slave).
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/spi_reg_tmo.sv
// Bus-ack timeout: reloads while clr is high, counts down while en is high,
// and flags expire in the TMO_CYC-th enabled cycle.
module spi_reg_tmo #(
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LOAD = 8'(TMO_CYC - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= LOAD;
    else if (clr)                cnt <= LOAD;
    else if (en && cnt != 8'd0)  cnt <= cnt - 8'd1;
  end

  assign expire = en && (cnt == 8'd0);

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns SPI byte frames ({rw, addr} command, then data/dummy bytes) into
// register bus accesses with auto-incrementing address.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a command byte
// ST_WAIT_WR | waiting for the next write data byte
// ST_WR_REQ  | write access outstanding on the bus
// ST_RD_REQ  | read access outstanding on the bus
// ST_WAIT_RD | read data staged in tx_data, waiting for dummy byte
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W   = 7,
  parameter int         TMO_CYC  = 64,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic [7:0] tx_data,
  spi_reg_bridge_if.master bus,
  output logic       busy,
  output logic       err_tmo,
  output logic       err_ovr,
  input  logic       err_clr
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [7:0]        wdata, wdata_n;
  logic [7:0]        tx, tx_n;
  logic              tmo, tmo_n;
  logic              ovr, ovr_n;
  logic              abort, abort_n;
  logic              tmo_set, ovr_set;
  logic              rx_ok, in_req, expire, done;

  assign rx_ok  = rx_flag & ~cs_n;
  assign in_req = (state == ST_WR_REQ) || (state == ST_RD_REQ);
  assign done   = bus.ack | expire;

  spi_reg_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_req),
    .en     (in_req),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      wdata <= 8'h00;
      tx    <= 8'h00;
      tmo   <= 1'b0;
      ovr   <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      tx    <= tx_n;
      tmo   <= tmo_n;
      ovr   <= ovr_n;
      abort <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    wdata_n = wdata;
    tx_n    = tx;
    abort_n = abort;
    tmo_set = 1'b0;
    ovr_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        abort_n = 1'b0;
        if (rx_ok) begin
          addr_n  = ADDR_W'(rx_data[RW_BIT-1:0]);
          state_n = rx_data[RW_BIT] ? ST_RD_REQ : ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        if (cs_n) state_n = ST_IDLE;
        else if (rx_flag) begin
          wdata_n = rx_data;
          state_n = ST_WR_REQ;
        end
      end
      ST_WAIT_RD: begin
        if (cs_n)         state_n = ST_IDLE;
        else if (rx_flag) state_n = ST_RD_REQ;
      end
      ST_WR_REQ, ST_RD_REQ: begin
        ovr_set = rx_ok;
        if (cs_n) abort_n = 1'b1;
        // Ack has priority over a coincident timeout.
        if (done) begin
          addr_n  = addr + ADDR_W'(1);
          tmo_set = ~bus.ack;
          if (state == ST_RD_REQ) tx_n = bus.ack ? bus.rdata : ERR_BYTE;
          if (abort || cs_n)           state_n = ST_IDLE;
          else if (state == ST_WR_REQ) state_n = ST_WAIT_WR;
          else                         state_n = ST_WAIT_RD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    tmo_n = (tmo & ~err_clr) | tmo_set;
    ovr_n = (ovr & ~err_clr) | ovr_set;
  end

  assign bus.req   = in_req;
  assign bus.we    = (state == ST_WR_REQ);
  assign bus.addr  = addr;
  assign bus.wdata = wdata;
  assign tx_data   = tx;
  assign busy      = (state != ST_IDLE);
  assign err_tmo   = tmo;
  assign err_ovr   = ovr;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected bus accesses are queued by the
// stimulus and popped by a bus monitor; status outputs are checked directly.
module tb_spi_reg_bridge;

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       cs_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic [7:0] tx_data;
  logic       busy;
  logic       err_tmo;
  logic       err_ovr;
  logic       err_clr;

  spi_reg_bridge_if #(.ADDR_W(7)) bus ();

  spi_reg_bridge #(.ADDR_W(7), .TMO_CYC(64), .ERR_BYTE(8'hEE)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs_n    (cs_n),
    .rx_data (rx_data),
    .rx_flag (rx_flag),
    .tx_data (tx_data),
    .bus     (bus),
    .busy    (busy),
    .err_tmo (err_tmo),
    .err_ovr (err_ovr),
    .err_clr (err_clr)
  );

  int   vectors = 0;
  int   miscompares = 0;
  txn_t exp_q[$];
  txn_t mon_t;
  logic [7:0] mem [0:127];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  bit   no_ack = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bus slave model with programmable ack latency.
  always @(posedge clk) begin
    #1;
    if (bus.ack) bus.ack = 1'b0;
    else if (!bus.req || no_ack || rst) wait_cnt = 0;
    else if (wait_cnt == ack_delay) begin
      bus.ack   = 1'b1;
      bus.rdata = mem[bus.addr];
      if (bus.we) mem[bus.addr] = bus.wdata;
      wait_cnt  = 0;
    end else wait_cnt++;
  end

  // Bus monitor: every acked access must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.req && bus.ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bus_access: unexpected we=%0b addr=%0h wdata=%0h, required none",
                 bus.we, bus.addr, bus.wdata);
      end else begin
        mon_t = exp_q.pop_front();
        if (bus.we !== mon_t.we || bus.addr !== mon_t.addr ||
            (mon_t.we && bus.wdata !== mon_t.data)) begin
          miscompares++;
          $display("FAIL bus_access: got we=%0b addr=%0h wdata=%0h, required we=%0b addr=%0h wdata=%0h",
                   bus.we, bus.addr, bus.wdata, mon_t.we, mon_t.addr, mon_t.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [6:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_flag = 1'b1;
    @(posedge clk); #1;
    rx_flag = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    while (bus.req && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.req) begin
      miscompares++;
      $display("FAIL %s: bus_req still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_bus_req"}, bus.req, 1'b0);
    chk({tag, "_bus_we"}, bus.we, 1'b0);
    chk({tag, "_bus_addr"}, bus.addr, 7'h00);
    chk({tag, "_bus_wdata"}, bus.wdata, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err_tmo"}, err_tmo, 1'b0);
    chk({tag, "_err_ovr"}, err_ovr, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    bus.ack = 1'b0; bus.rdata = 8'h00;
    rst = 1'b1; cs_n = 1'b1; rx_data = 8'h00; rx_flag = 1'b0; err_clr = 1'b0;
    #2 chk_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Burst write: addr 5 = A1, addr 6 = B2.
    cs_n = 1'b0;
    push(1'b1, 7'h05, 8'hA1);
    push(1'b1, 7'h06, 8'hB2);
    send_byte(8'h05); send_byte(8'hA1); send_byte(8'hB2);
    repeat (3) @(negedge clk);
    chk("wr_err_tmo", err_tmo, 1'b0);
    chk("wr_err_ovr", err_ovr, 1'b0);
    #1 cs_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("wr_busy_after_cs", busy, 1'b0);

    // Burst read from 0x10 with two dummy bytes.
    mem[7'h10] = 8'h3C; mem[7'h11] = 8'h4D; mem[7'h12] = 8'h5E;
    push(1'b0, 7'h10, 8'h00);
    push(1'b0, 7'h11, 8'h00);
    push(1'b0, 7'h12, 8'h00);
    #1 cs_n = 1'b0;
    send_byte(8'h90);
    repeat (3) @(negedge clk);
    chk("rd_tx_first", tx_data, 8'h3C);
    send_byte(8'hFF);
    repeat (3) @(negedge clk);
    chk("rd_tx_second", tx_data, 8'h4D);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("rd_tx_third", tx_data, 8'h5E);
    #1 cs_n = 1'b1;

    // Address wrap 7F -> 00.
    push(1'b1, 7'h7F, 8'h11);
    push(1'b1, 7'h00, 8'h22);
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'h7F); send_byte(8'h11); send_byte(8'h22);
    repeat (3) @(negedge clk);
    #1 cs_n = 1'b1;

    // Read timeout: no ack ever.
    no_ack = 1'b1;
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'h82);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.req) break;
      n++;
    end
    chk("tmo_req_cycles", n, 64);
    chk("tmo_tx_data", tx_data, 8'hEE);
    chk("tmo_err_tmo", err_tmo, 1'b1);
    pulse_clr();
    @(negedge clk);
    chk("tmo_err_clr", err_tmo, 1'b0);
    #1 cs_n = 1'b1; no_ack = 1'b0;

    // Overrun: slow ack, extra byte during the write access.
    ack_delay = 40;
    push(1'b1, 7'h03, 8'h55);
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'h03); send_byte(8'h55);
    repeat (7) @(posedge clk);
    send_byte(8'h66);
    @(negedge clk);
    chk("ovr_set", err_ovr, 1'b1);
    wait_req_low("ovr_req_drop");
    repeat (4) @(negedge clk);
    chk("ovr_sticky", err_ovr, 1'b1);
    chk("ovr_no_tmo", err_tmo, 1'b0);
    #1 cs_n = 1'b1;
    pulse_clr();
    @(negedge clk);
    chk("ovr_err_clr", err_ovr, 1'b0);

    // Ack arrives in the very cycle the timeout expires: ack wins.
    ack_delay = 63;
    mem[7'h20] = 8'h77;
    push(1'b0, 7'h20, 8'h00);
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'hA0);
    wait_req_low("tie_req_drop");
    chk("tie_tx_data", tx_data, 8'h77);
    chk("tie_no_tmo", err_tmo, 1'b0);
    #1 cs_n = 1'b1; ack_delay = 0;

    // cs_n rising in WAIT_WR aborts on the next edge.
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'h08);
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    @(posedge clk); #1 cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_after", busy, 1'b0);

    // Bytes with cs_n high are ignored.
    send_byte(8'h85);
    @(negedge clk);
    chk("csn_ignore_busy", busy, 1'b0);

    // Reset in the middle of a read access, then an immediate command.
    ack_delay = 20;
    @(posedge clk); #1 cs_n = 1'b0;
    send_byte(8'h85);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    ack_delay = 0;
    push(1'b1, 7'h09, 8'h99);
    send_byte(8'h09); send_byte(8'h99);
    repeat (5) @(negedge clk);
    #1 cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 7, register address width; the command byte carries {rw, addr[6:0]}.
REQ-002 Parameter TMO_CYC, default 64, bus-ack timeout in clk cycles, legal range 2..255.
REQ-003 Parameter ERR_BYTE, default 8'hEE, tx_data value returned on a timed-out read.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 cs_n  in  1  SPI chip select, active-low, already synchronous to clk.
REQ-007 rx_data  in  8  byte received by the SPI slave; valid when rx_flag=1.
REQ-008 rx_flag  in  1  one-cycle pulse per received byte.
REQ-009 tx_data  out  8  byte the SPI slave shifts out during the next byte frame.
REQ-010 bus_req  out  1  register bus request, held until bus_ack or timeout.
REQ-011 bus_we  out  1  1=write, 0=read; stable while bus_req=1.
REQ-012 bus_addr  out  ADDR_W  register address; stable while bus_req=1.
REQ-013 bus_wdata  out  8  write data; stable while bus_req=1.
REQ-014 bus_rdata  in  8  read data; valid when bus_ack=1 and bus_we=0.
REQ-015 bus_ack  in  1  one-cycle completion pulse from the register bus.
REQ-016 busy  out  1  1 whenever state is not IDLE.
REQ-017 err_tmo  out  1  sticky flag, bus timeout occurred.
REQ-018 err_ovr  out  1  sticky flag, byte arrived while a bus access was pending.
REQ-019 err_clr  in  1  one-cycle pulse that clears err_tmo and err_ovr.

Function
REQ-020 Reset outputs: tx_data=8'h00, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, err_tmo=0, err_ovr=0; state is IDLE.
REQ-021 States: IDLE, WAIT_WR (awaiting data byte), WR_REQ, RD_REQ, WAIT_RD (awaiting dummy byte).
REQ-022 In IDLE, an rx_flag with cs_n=0 is the command byte: it latches addr=rx_data[6:0]; rx_data[7]=0 moves to WAIT_WR, rx_data[7]=1 moves to RD_REQ on the next cycle.
REQ-023 In WAIT_WR, an rx_flag loads bus_wdata=rx_data, asserts bus_req=1 and bus_we=0→1 on the next cycle, and moves to WR_REQ.
REQ-024 In RD_REQ, bus_req=1 and bus_we=0 with the current address; on bus_ack, tx_data<=bus_rdata in the same edge and the block moves to WAIT_RD.
REQ-025 In WAIT_RD, an rx_flag (dummy byte, value ignored) moves to RD_REQ for the next address.
REQ-026 On bus_ack in WR_REQ, bus_req drops on the next edge and the block returns to WAIT_WR.
REQ-027 After every completed or timed-out access the address increments by 1, modulo 2^ADDR_W (7'h7F wraps to 7'h00).
REQ-028 bus_req deasserts in the cycle after bus_ack; no new request is issued in the same cycle as an ack.
REQ-029 Timeout: the counter clears on request issue and increments each cycle while bus_req=1 without ack; at count TMO_CYC-1 it drops bus_req and sets err_tmo; a read timeout loads tx_data=ERR_BYTE; the next state is the same as on ack.
REQ-030 bus_ack and timeout in the same cycle: the ack wins and err_tmo is not set.
REQ-031 An rx_flag in WR_REQ or RD_REQ sets err_ovr and the byte is dropped; the state is unchanged.
REQ-032 err_clr and a new error event in the same cycle: the flag ends set.
REQ-033 cs_n=1 in WAIT_WR or WAIT_RD returns the block to IDLE on the next edge; tx_data holds its value.
REQ-034 cs_n=1 in WR_REQ or RD_REQ lets the access complete (ack or timeout), then the block goes to IDLE.
REQ-035 rx_flag is ignored whenever cs_n=1.
REQ-036 tx_data changes only on read ack, read timeout, or reset.

Reset
REQ-037 Asserting rst at any time, including mid-access, forces the REQ-020 values asynchronously; an outstanding bus access is abandoned.
REQ-038 Reset release needs no extra cycles; the first rx_flag after release may be a command byte.

Structure
REQ-039 A shared package spi_reg_pkg holds the state enumeration, the command rw bit index (7), and the ERR_BYTE default.
REQ-040 A sub-module spi_reg_tmo (clear/enable-in, expire-out counter, parameter TMO_CYC) implements REQ-029.

Verification
REQ-041 Write: cs_n=0, bytes 8'h05, 8'hA1, 8'hB2 -> writes addr 5=A1 and addr 6=B2, err flags 0.
REQ-042 Read: reg 7'h10=8'h3C, 7'h11=8'h4D; bytes 8'h90 then two dummies -> tx_data=3C before the 2nd byte and 4D before the 3rd.
REQ-043 Wrap: write command 8'h7F with two data bytes -> writes to addr 7F then addr 00.
REQ-044 Timeout: read command 8'h82, bus_ack never asserted -> bus_req drops after 64 cycles, tx_data=EE, err_tmo=1; err_clr -> err_tmo=0.
REQ-045 Overrun: bus_ack delayed 40 cycles, second data byte arrives at cycle 10 -> err_ovr=1, only the first write occurs.
REQ-046 Abort: cs_n rises in WAIT_WR -> IDLE next cycle; rst asserted during RD_REQ -> all outputs at reset values immediately.
